// File: rtl/ff_reg_arbiter_if.sv
// Bus between control clients and the shared-register arbiter.
// req/gnt handshake: a requester holds req with a stable op/data until it sees gnt;
// the command is captured on the edge that raises gnt, and req must drop before
// the following arbitration edge unless another transaction is wanted.
interface ff_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] data;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   busy;
  logic                   dbg_state;

  modport master (
    output req, op, data,
    input  gnt, q, done, done_id, busy, dbg_state
  );

  modport slave (
    input  req, op, data,
    output gnt, q, done, done_id, busy, dbg_state
  );
endinterface

// File: rtl/ff_reg_arbiter.sv
// Round-robin arbiter serialising hold/clear/load/toggle commands from N_REQ
// clients onto one shared WIDTH-bit register; one command per two cycles.
module ff_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 res,
  ff_reg_arbiter_if.slave      bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t             state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [WIDTH-1:0]   q, q_n;
  logic [N_REQ-1:0]   gnt, gnt_n;
  logic               done, done_n;
  logic [ID_W-1:0]    done_id, done_id_n;
  logic [1:0]         op_r, op_n;
  logic [WIDTH-1:0]   data_r, data_n;
  logic [ID_W-1:0]    id_r, id_n;
  logic [ID_W:0]      pick;

  // Returns {found, index}: first set request at or above p, wrapping to 0.
  // Scanning downward lets the smallest offset from p overwrite the rest.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  p);
    logic [ID_W:0] sel;
    int            k;
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (r[k]) sel = {1'b1, ID_W'(k)};
    end
    return sel;
  endfunction

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    q_n       = q;
    gnt_n     = '0;
    done_n    = 1'b0;
    done_id_n = done_id;
    op_n      = op_r;
    data_n    = data_r;
    id_n      = id_r;
    pick      = rr_pick(bus.req, ptr);

    case (state)
      IDLE: begin
        if (pick[ID_W]) begin
          id_n    = pick[ID_W-1:0];
          op_n    = bus.op[2*id_n +: 2];
          data_n  = bus.data[WIDTH*id_n +: WIDTH];
          gnt_n   = N_REQ'(1) << id_n;
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (op_r)
          OP_HOLD:   q_n = q;
          OP_CLEAR:  q_n = '0;
          OP_LOAD:   q_n = data_r;
          OP_TOGGLE: q_n = q ^ data_r;
          default:   q_n = q;
        endcase
        done_n    = 1'b1;
        done_id_n = id_r;
        // Even a hold completes, so the pointer always moves past the winner.
        ptr_n     = (id_r == ID_W'(N_REQ - 1)) ? '0 : id_r + 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      ptr     <= '0;
      q       <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      op_r    <= '0;
      data_r  <= '0;
      id_r    <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      q       <= q_n;
      gnt     <= gnt_n;
      done    <= done_n;
      done_id <= done_id_n;
      op_r    <= op_n;
      data_r  <= data_n;
      id_r    <= id_n;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.q         = q;
  assign bus.done      = done;
  assign bus.done_id   = done_id;
  assign bus.busy      = (state == EXEC);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ff_reg_arbiter.sv
// Self-checking bench for ff_reg_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the shared register.
module tb_ff_reg_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CMD_W = ID_W + 2 + WIDTH;

  logic clk;
  logic res;

  ff_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  ff_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Granted-but-not-completed commands, packed {id, op, data}.
  logic [CMD_W-1:0] exp_q[$];

  int m_q, m_ptr, m_gnt, m_done, m_done_id, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predicts what the coming clock edge does, from current inputs.
  task automatic model_step();
    logic [CMD_W-1:0] cmd;
    int id, op, d;
    if (res) begin
      exp_q.delete();
      m_q = 0; m_ptr = 0; m_gnt = 0; m_done = 0; m_done_id = 0; m_busy = 0;
    end else if (exp_q.size() > 0) begin
      cmd = exp_q.pop_front();
      id  = int'(cmd[CMD_W-1 -: ID_W]);
      op  = int'(cmd[WIDTH +: 2]);
      d   = int'(cmd[WIDTH-1:0]);
      case (op)
        0: m_q = m_q;
        1: m_q = 0;
        2: m_q = d;
        default: m_q = m_q ^ d;
      endcase
      m_done = 1; m_done_id = id; m_ptr = (id + 1) % N_REQ;
      m_gnt = 0; m_busy = 0;
    end else begin
      m_done = 0; m_gnt = 0; m_busy = 0;
      for (int i = 0; i < N_REQ; i++) begin
        int k;
        k = (m_ptr + i) % N_REQ;
        if (bus.req[k]) begin
          exp_q.push_back({ID_W'(k), bus.op[2*k +: 2], bus.data[WIDTH*k +: WIDTH]});
          m_gnt = 1 << k;
          m_busy = 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("gnt",   32'(bus.gnt),       32'(m_gnt));
    check("q",     32'(bus.q),         32'(m_q));
    check("done",  32'(bus.done),      32'(m_done));
    check("busy",  32'(bus.busy),      32'(m_busy));
    check("state", 32'(bus.dbg_state), 32'(m_busy));
    if (m_done != 0) check("done_id", 32'(bus.done_id), 32'(m_done_id));
  endtask

  // ---------------- drivers ----------------
  task automatic set_cmd(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
    bus.op[2*id +: 2]        = op;
    bus.data[WIDTH*id +: WIDTH] = d;
  endtask

  // One request from a single client; operand is scrambled while granted.
  task automatic txn(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
    bus.req = N_REQ'(1) << id;
    set_cmd(id, op, d);
    tick();
    check("txn_gnt", 32'(bus.gnt), 32'(1 << id));
    bus.data[WIDTH*id +: WIDTH] = WIDTH'($urandom);
    bus.op[2*id +: 2] = 2'($urandom);
    bus.req = '0;
    tick();
    check("txn_done", 32'(bus.done), 32'd1);
    check("txn_done_id", 32'(bus.done_id), 32'(id));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N_REQ-1:0] fair_exp [5];
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;

    res = 1'b1;
    bus.req = '1;
    bus.op = {N_REQ{2'b10}};
    bus.data = {N_REQ{8'h5A}};
    m_q = 0; m_ptr = 0; m_gnt = 0; m_done = 0; m_done_id = 0; m_busy = 0;

    // Reset with all clients requesting loads.
    tick();
    tick();
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    res = 1'b0;
    tick();
    check("first_gnt_after_rst", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    check("first_load", 32'(bus.q), 32'h5A);

    // Single load then the command set.
    txn(2, 2'b10, 8'hA5);
    check("load_a5", 32'(bus.q), 32'hA5);
    txn(2, 2'b11, 8'h0F);
    check("toggle_0f", 32'(bus.q), 32'hAA);
    txn(2, 2'b00, 8'hFF);
    check("hold", 32'(bus.q), 32'hAA);
    txn(2, 2'b01, 8'hFF);
    check("clear", 32'(bus.q), 32'h00);

    // Fairness from ptr=0.
    res = 1'b1;
    tick();
    res = 1'b0;
    bus.req = '1;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < N_REQ; i++) set_cmd(i, 2'($urandom), WIDTH'($urandom));
      tick();
      check("fair_gnt", 32'(bus.gnt), 32'(fair_exp[j]));
      tick();
      check("fair_done_id", 32'(bus.done_id), 32'(j % N_REQ));
    end
    bus.req = '0;
    tick();

    // Wrap-around: ptr=3 after client 2 completes.
    txn(2, 2'b10, 8'h11);
    bus.req = 4'b1001;
    tick();
    check("wrap_gnt3", 32'(bus.gnt), 32'h8);
    tick();
    tick();
    check("wrap_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("solo_gnt0", 32'(bus.gnt), 32'h1);
      tick();
    end
    bus.req = '0;
    tick();

    // Reset at the EXEC edge discards the pending load.
    txn(0, 2'b10, 8'h55);
    check("pre_rst_q", 32'(bus.q), 32'h55);
    bus.req = 4'b0001;
    set_cmd(0, 2'b10, 8'h3C);
    tick();
    res = 1'b1;
    bus.req = '0;
    tick();
    check("midop_q", 32'(bus.q), 32'h0);
    check("midop_done", 32'(bus.done), 32'h0);
    res = 1'b0;
    bus.req = '1;
    tick();
    check("midop_ptr0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      res = ($urandom_range(0, 49) == 0);
      bus.req = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom);
      bus.op = (2*N_REQ)'($urandom);
      bus.data = (WIDTH*N_REQ)'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
